uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, glitch reject on start, framing-error pulse.
// rx_valid ~9.5 bit periods after the start edge; no backpressure, rx_data is overwritten by each good byte.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = (CLKS_PER_BIT - 1) / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    data_n;
  logic          valid_n, ferr_n, busy_n;
  logic          rx_meta, rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= WAIT_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_idx      <= bit_idx_n;
      shreg        <= shreg_n;
      rx_data      <= data_n;
      rx_valid     <= valid_n;
      rx_frame_err <= ferr_n;
      rx_busy      <= busy_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    data_n    = rx_data;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      WAIT_IDLE: if (rx_s) state_n = IDLE;
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n   = DATA;
            bit_idx_n = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        // Leaving at mid-stop leaves half a bit to catch a zero-gap start edge.
        if (cnt == BIT_END) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shreg;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = WAIT_IDLE;
    endcase
    // Registered from next state so rx_busy tracks state != IDLE yet resets to 0.
    busy_n = (state_n != IDLE);
  end
endmodule

// File: tb/tb_uart_rx.sv
// Randomised line BFM feeding uart_rx; expected bytes/framing errors are queued at issue and checked by a monitor.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CLK_NS   = 20;
  localparam int CPB      = 50_000_000 / 115200;
  localparam int HALF     = (CPB - 1) / 2;
  localparam int BIT_NS   = CPB * CLK_NS;
  localparam int LAT_MIN  = 2 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_busy;

  typedef struct {
    bit       is_err;
    bit [7:0] data;
  } exp_t;

  exp_t     exp_q[$];
  realtime  valid_times[$];
  realtime  fall_t;
  bit [7:0] model_last;
  int       n_cmp = 0;
  int       n_err = 0;

  uart_rx dut (
    .clk(clk), .rst(rst), .rx_serial(rx_serial), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );

  always #(CLK_NS / 2) clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $realtime);
    end
  endtask

  // Reference model: a frame with stop=1 yields its byte; stop=0 yields a framing error, data unchanged.
  task automatic expect_frame(input bit [7:0] d, input bit stop);
    exp_t e;
    e.is_err = !stop;
    e.data   = stop ? d : model_last;
    if (stop) model_last = d;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input bit [7:0] d, input int bit_ns, input bit stop, input int hold_low);
    fall_t = $realtime;
    rx_serial = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      #(bit_ns);
    end
    rx_serial = stop;
    #(bit_ns);
    if (hold_low > 0) #(bit_ns * hold_low);
    rx_serial = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2 * CPB && exp_q.size() != 0; i++) @(negedge clk);
    check({"drain_", name}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rx_valid || rx_frame_err) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data=0x%0h, none expected at %0t",
                 rx_valid, rx_frame_err, rx_data, $realtime);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 32'({rx_valid, rx_frame_err}), e.is_err ? 1 : 2);
        check("rx_data", 32'(rx_data), 32'(e.data));
      end
      if (rx_valid) valid_times.push_back($realtime);
    end
  end

  initial begin
    #(95_000 * CLK_NS);
    $display("FAIL watchdog: simulation did not complete, %0d frames still expected", exp_q.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit [7:0] d;
    int       bn, lat;
    bit       seen;
    realtime  dt;

    rst = 1'b1;
    rx_serial = 1'b1;
    model_last = 8'h00;
    #55;
    check("reset_rx_data", 32'(rx_data), 0);
    check("reset_rx_valid", 32'(rx_valid), 0);
    check("reset_frame_err", 32'(rx_frame_err), 0);
    check("reset_rx_busy", 32'(rx_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_busy", 32'(rx_busy), 0);

    // Nominal bytes, first one clock-aligned for a latency check
    expect_frame(8'hA5, 1'b1);
    send_frame(8'hA5, BIT_NS, 1'b1, 0);
    drain("A5");
    if (valid_times.size() == 0) begin
      check("latency_pulse_seen", 0, 1);
    end else begin
      lat = int'((valid_times[$] - fall_t) / CLK_NS);
      check("latency_in_window", int'(lat >= LAT_MIN && lat <= LAT_MIN + 6), 1);
    end
    foreach (valid_times[i]) valid_times.delete(i);
    expect_frame(8'h00, 1'b1);
    send_frame(8'h00, BIT_NS, 1'b1, 0);
    expect_frame(8'hFF, 1'b1);
    send_frame(8'hFF, BIT_NS, 1'b1, 0);
    drain("00_FF");

    // Zero-gap back-to-back
    valid_times.delete();
    expect_frame(8'h48, 1'b1);
    expect_frame(8'h69, 1'b1);
    send_frame(8'h48, BIT_NS, 1'b1, 0);
    send_frame(8'h69, BIT_NS, 1'b1, 0);
    drain("b2b");
    check("b2b_pulse_count", valid_times.size(), 2);
    if (valid_times.size() == 2) begin
      dt = (valid_times[1] - valid_times[0]) / CLK_NS;
      check("b2b_spacing", int'(dt >= 10 * CPB - 20 && dt <= 10 * CPB + 20), 1);
    end

    // Framing error followed by a break, then a good frame
    expect_frame(8'h3C, 1'b0);
    send_frame(8'h3C, BIT_NS, 1'b0, 2);
    drain("frame_err");
    #(BIT_NS);
    expect_frame(8'h55, 1'b1);
    send_frame(8'h55, BIT_NS, 1'b1, 0);
    drain("55");

    // Short low glitch must be rejected
    #(BIT_NS);
    @(negedge clk);
    rx_serial = 1'b0;
    #100;
    rx_serial = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = rx_busy;
    end
    check("glitch_busy_seen", int'(seen), 1);
    for (int i = 0; i < HALF + 3 && rx_busy; i++) @(negedge clk);
    check("glitch_busy_low", 32'(rx_busy), 0);
    #(BIT_NS);

    // Baud tolerance at +2% and -2%
    expect_frame(8'hC3, 1'b1);
    send_frame(8'hC3, 8507, 1'b1, 0);
    expect_frame(8'hC3, 1'b1);
    send_frame(8'hC3, 8854, 1'b1, 0);
    drain("tol");

    // Reset during data bit 3
    fork
      send_frame(8'hF0, BIT_NS, 1'b1, 0);
      begin
        #(BIT_NS * 4 + BIT_NS / 2);
        rst = 1'b1;
        #50;
        check("midrst_rx_data", 32'(rx_data), 0);
        check("midrst_rx_valid", 32'(rx_valid), 0);
        check("midrst_frame_err", 32'(rx_frame_err), 0);
        check("midrst_rx_busy", 32'(rx_busy), 0);
        #50;
        rst = 1'b0;
        model_last = 8'h00;
      end
    join
    #(BIT_NS * 10);
    check("postrst_busy", 32'(rx_busy), 0);
    expect_frame(8'h81, 1'b1);
    send_frame(8'h81, BIT_NS, 1'b1, 0);
    drain("81");

    // Random bytes at random rates within tolerance and random gaps
    for (int i = 0; i < 4; i++) begin
      d  = 8'($urandom_range(0, 255));
      bn = int'($urandom_range(8507, 8854));
      expect_frame(d, 1'b1);
      send_frame(d, bn, 1'b1, 0);
      #(CLK_NS * int'($urandom_range(0, 300)));
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
